stage_fetch_prefetch: RTL and testbench
=======================================

Name: stage_fetch_prefetch

Overview:
- Replacement fetch stage: owns the PC, issues word reads to instruction memory, and buffers returned 24-bit instructions in a small prefetch FIFO.
- Delivers one instruction per cycle, with its PC, to the fetch→decode pipe register through a valid/ready handshake.
- Accepts the branch/PC-write redirect coming back from the memory/write-back stage, flushing buffered and in-flight fetches.

Parameters:
- instructionSize, 24, instruction word width.
- pcSize, 16, PC / instruction address width (word addressed, +1 per instruction).
- fifoDepth, 4, prefetch FIFO entries (power of two, ≥2).
- maxOutstanding, 4, max issued-but-unreturned memory requests (≤ fifoDepth).
- resetPc, 16'h0000, PC after reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- pcWrEn  in  1  redirect request, one cycle.
- newPc  in  pcSize  redirect target, valid with pcWrEn.
- imem_req  out  1  read request this cycle.
- imem_addr  out  pcSize  request address.
- imem_gnt  in  1  memory accepts the request (req&&gnt = issued).
- imem_rvalid  in  1  read data valid; responses return in issue order, latency ≥1.
- imem_rdata  in  instructionSize  read data.
- instr_valid  out  1  instruction available to decode.
- instr_ready  in  1  decode accepts (stall when low).
- instruction  out  instructionSize  FIFO head.
- instr_pc  out  pcSize  PC of the FIFO head.

Behaviour:
- Reset (reset=0, async): fetch_pc=resetPc, deliver_pc=resetPc, FIFO empty, outstanding=0, discard=0, state=BOOT. Outputs: imem_req=0, imem_addr=resetPc, instr_valid=0, instruction=0, instr_pc=resetPc.
- FSM:
  - BOOT: one cycle with no requests, then RUN.
  - RUN: normal operation.
  - Reset mid-operation returns to BOOT from any state. Responses returning after reset are not counted and are dropped in BOOT.
- Issue: imem_req=1 in RUN when (fifo_count + outstanding − discard) < fifoDepth, outstanding < maxOutstanding, and pcWrEn=0. imem_addr=fetch_pc. On req&&gnt: fetch_pc+=1 (wraps 16'hFFFF→0), outstanding+=1. imem_req and imem_addr hold stable until gnt.
- Response: on imem_rvalid, outstanding−=1.
  - If discard>0: discard−=1 and the data is dropped.
  - Otherwise the data is pushed to the FIFO.
  - The credit rule guarantees no push to a full FIFO. Overflow is an assertion failure.
- Output: instr_valid = FIFO non-empty && !pcWrEn. instruction and instr_pc are the head entry and deliver_pc, combinationally from FIFO storage. On valid&&ready: pop, deliver_pc+=1 (wraps).
- Redirect (pcWrEn=1), highest priority, takes effect at the clock edge:
  - Clear the FIFO.
  - fetch_pc=newPc, deliver_pc=newPc.
  - discard = outstanding after this cycle's issue/response updates. A response arriving in the redirect cycle is dropped and does not count into discard.
  - No issue and no pop in the redirect cycle.
  - The first request to newPc goes out the next cycle.
  - Back-to-back redirects: the last one wins.
- Simultaneous push and pop when the FIFO is full or empty: both take effect, with no bubble on pass-through. An empty FIFO still takes ≥1 cycle from rvalid to instr_valid, because the FIFO is registered.
- Minimum redirect-to-instr_valid latency = 1 (issue) + memory latency + 1.

Test Plan:
- Reset release, 1-cycle memory, gnt=1, ready=1 → requests to 0,1,2,…; instr_valid first high 3 cycles after BOOT; instr_pc sequence 0,1,2,3 with matching rdata.
- instr_ready=0 for 10 cycles → issue stops at 4 buffered + 0 outstanding. No overflow; head stays pc=N until ready, then 4 instructions stream back-to-back.
- Latency 3 memory, 3 outstanding at addrs 8,9,10, pcWrEn with newPc=0x0040 → the 3 responses are dropped. Next imem_addr=0x0040; first delivered instr_pc=0x0040.
- pcWrEn in the same cycle as rvalid and valid&&ready → that response is dropped, instr_valid=0 that cycle, deliver_pc=newPc next cycle.
- fetch_pc=0xFFFE → delivered instr_pc 0xFFFE, 0xFFFF, 0x0000 (wrap).
- reset asserted while 2 requests are outstanding and FIFO=3 → outputs return to reset values immediately. After release, BOOT one cycle, then fetch from resetPc; stale rvalids are ignored.

Source files
------------

// File: rtl/stage_fetch_prefetch_if.sv
// Fetch-stage bundle: redirect input, instruction-memory request/response,
// and the valid/ready handshake into the fetch->decode pipe register.
interface stage_fetch_prefetch_if #(
    parameter int instructionSize = 24,
    parameter int pcSize          = 16
);
    logic                       pcWrEn;
    logic [pcSize-1:0]          newPc;
    logic                       imem_req;
    logic [pcSize-1:0]          imem_addr;
    logic                       imem_gnt;
    logic                       imem_rvalid;
    logic [instructionSize-1:0] imem_rdata;
    logic                       instr_valid;
    logic                       instr_ready;
    logic [instructionSize-1:0] instruction;
    logic [pcSize-1:0]          instr_pc;

    modport master (
        input  pcWrEn, newPc, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
        output imem_req, imem_addr, instr_valid, instruction, instr_pc
    );

    modport slave (
        output pcWrEn, newPc, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
        input  imem_req, imem_addr, instr_valid, instruction, instr_pc
    );
endinterface

// File: rtl/stage_fetch_prefetch.sv
// Fetch stage: owns the PC, issues credit-limited word reads to instruction
// memory, buffers in-order responses in a small FIFO and hands them to decode.

module stage_fetch_prefetch_chk #(
    parameter int CW             = 3,
    parameter int fifoDepth      = 4,
    parameter int maxOutstanding = 4
) (
    input logic          clk,
    input logic          reset,
    input logic          i_push,
    input logic          i_pop,
    input logic [CW-1:0] i_count,
    input logic [CW-1:0] i_outstanding
);
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(i_push && !i_pop && (i_count == CW'(fifoDepth))));

    a_out_bound: assert property (@(posedge clk) disable iff (!reset)
        (i_outstanding <= CW'(maxOutstanding)));
endmodule

module stage_fetch_prefetch #(
    parameter int                       instructionSize = 24,
    parameter int                       pcSize          = 16,
    parameter int                       fifoDepth       = 4,
    parameter int                       maxOutstanding  = 4,
    parameter logic [pcSize-1:0]        resetPc         = 16'h0000
) (
    input logic                 clk,
    input logic                 reset,
    stage_fetch_prefetch_if.master bus
);
    localparam int PW = $clog2(fifoDepth);
    localparam int CW = PW + 1;
    localparam logic [CW:0]        DEPTH_C = (CW+1)'(fifoDepth);
    localparam logic [CW-1:0]      MAXO_C  = CW'(maxOutstanding);
    localparam logic [pcSize-1:0]  PC_ONE  = {{(pcSize-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]      PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]      CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [pcSize-1:0]          r_fetch_pc;
    logic [pcSize-1:0]          r_deliver_pc;
    logic [CW-1:0]              r_count;
    logic [CW-1:0]              r_outstanding;
    logic [CW-1:0]              r_discard;
    logic [PW-1:0]              r_rd_ptr;
    logic [PW-1:0]              r_wr_ptr;
    logic [instructionSize-1:0] r_mem [fifoDepth];

    logic          w_run;
    logic [CW:0]   w_credit;
    logic          w_req;
    logic          w_issue;
    logic          w_resp;
    logic          w_valid;
    logic          w_pop;
    logic          w_push;
    logic [CW-1:0] w_out_nxt;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: a single quiet BOOT cycle, then RUN until reset
    always_comb begin
        w_state_nxt = r_state;
        w_run       = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_RUN;
                w_run       = 1'b0;
            end
            ST_RUN: begin
                w_state_nxt = ST_RUN;
                w_run       = 1'b1;
            end
            default: begin
                w_state_nxt = ST_BOOT;
                w_run       = 1'b0;
            end
        endcase
    end

    // Credit covers buffered plus live in-flight words; discarded ones never land
    always_comb begin
        w_credit  = {1'b0, r_count} + {1'b0, r_outstanding} - {1'b0, r_discard};
        w_req     = w_run && (w_credit < DEPTH_C) && (r_outstanding < MAXO_C) && !bus.pcWrEn;
        w_issue   = w_req && bus.imem_gnt;
        w_resp    = w_run && bus.imem_rvalid && (r_outstanding != {CW{1'b0}});
        w_valid   = (r_count != {CW{1'b0}}) && !bus.pcWrEn;
        w_pop     = w_valid && bus.instr_ready;
        w_push    = w_resp && !bus.pcWrEn && (r_discard == {CW{1'b0}});
        w_out_nxt = r_outstanding + CW'(w_issue) - CW'(w_resp);
    end

    // PC, credit and FIFO pointer bookkeeping; redirect overrides everything
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_pc    <= resetPc;
            r_deliver_pc  <= resetPc;
            r_count       <= {CW{1'b0}};
            r_outstanding <= {CW{1'b0}};
            r_discard     <= {CW{1'b0}};
            r_rd_ptr      <= {PW{1'b0}};
            r_wr_ptr      <= {PW{1'b0}};
        end else if (bus.pcWrEn) begin
            r_fetch_pc    <= bus.newPc;
            r_deliver_pc  <= bus.newPc;
            r_count       <= {CW{1'b0}};
            r_outstanding <= w_out_nxt;
            r_discard     <= w_out_nxt;
            r_rd_ptr      <= {PW{1'b0}};
            r_wr_ptr      <= {PW{1'b0}};
        end else begin
            r_outstanding <= w_out_nxt;
            r_count       <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + PC_ONE;
            end else begin
                r_fetch_pc <= r_fetch_pc;
            end
            if (w_resp && (r_discard != {CW{1'b0}})) begin
                r_discard <= r_discard - CNT_ONE;
            end else begin
                r_discard <= r_discard;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr     <= r_rd_ptr + PTR_ONE;
                r_deliver_pc <= r_deliver_pc + PC_ONE;
            end else begin
                r_rd_ptr     <= r_rd_ptr;
                r_deliver_pc <= r_deliver_pc;
            end
        end
    end

    // FIFO storage; cleared on reset so the head reads zero out of reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < fifoDepth; i++) begin
                r_mem[i] <= {instructionSize{1'b0}};
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= bus.imem_rdata;
        end else begin
            r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
        end
    end

    assign bus.imem_req    = w_req;
    assign bus.imem_addr   = r_fetch_pc;
    assign bus.instr_valid = w_valid;
    assign bus.instruction = r_mem[r_rd_ptr];
    assign bus.instr_pc    = r_deliver_pc;

    stage_fetch_prefetch_chk #(
        .CW             (CW),
        .fifoDepth      (fifoDepth),
        .maxOutstanding (maxOutstanding)
    ) u_chk (
        .clk           (clk),
        .reset         (reset),
        .i_push        (w_push),
        .i_pop         (w_pop),
        .i_count       (r_count),
        .i_outstanding (r_outstanding)
    );
endmodule

// File: tb/tb_stage_fetch_prefetch.sv
// Randomized bench: in-order latency memory model plus a stream-level
// reference (delivered PCs run consecutively from the last redirect/reset).
module tb_stage_fetch_prefetch;
    localparam int IW   = 24;
    localparam int PW   = 16;
    localparam int MAXO = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    stage_fetch_prefetch_if #(.instructionSize(IW), .pcSize(PW)) bus ();

    stage_fetch_prefetch #(
        .instructionSize (IW),
        .pcSize          (PW),
        .fifoDepth       (4),
        .maxOutstanding  (MAXO),
        .resetPc         (16'h0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [PW-1:0] exp_fetch, exp_deliver;
    logic [PW-1:0] addr_q[$];
    int            due_q[$];
    int            last_due, cyc, delivered, first_req, first_valid;
    int            lat_min, lat_max, gnt_pct, rdy_pct, redir_pct;
    bit            force_redir, stale_now, seen_ffff, saw_wrap;
    logic [PW-1:0] force_pc;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [IW-1:0] mem_word(input logic [PW-1:0] a);
        return {a[7:0] ^ a[15:8] ^ 8'hC3, a};
    endfunction

    task automatic drive_inputs();
        bus.imem_gnt    = ($urandom_range(99) < gnt_pct);
        bus.instr_ready = ($urandom_range(99) < rdy_pct);
        if (force_redir) begin
            bus.pcWrEn  = 1'b1;
            bus.newPc   = force_pc;
            force_redir = 1'b0;
        end else begin
            bus.pcWrEn = ($urandom_range(99) < redir_pct);
            bus.newPc  = 16'($urandom);
        end
        if (addr_q.size() > 0 && due_q[0] <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(addr_q[0]);
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = 24'($urandom);
        end
    endtask

    task automatic observe();
        int due;
        if (bus.imem_rvalid && !stale_now && addr_q.size() > 0) begin
            void'(addr_q.pop_front());
            void'(due_q.pop_front());
        end
        if (cyc == 0) check_val("boot_no_req", 32'(bus.imem_req), 32'd0);
        if (bus.pcWrEn) begin
            check_val("redir_no_req", 32'(bus.imem_req), 32'd0);
            check_val("redir_no_valid", 32'(bus.instr_valid), 32'd0);
            exp_fetch   = bus.newPc;
            exp_deliver = bus.newPc;
        end else begin
            if (bus.imem_req) begin
                if (first_req < 0) first_req = cyc;
                check_val("req_addr", 32'(bus.imem_addr), 32'(exp_fetch));
                if (bus.imem_gnt) begin
                    due = cyc + int'($urandom_range(lat_max, lat_min));
                    if (due <= last_due) due = last_due + 1;
                    addr_q.push_back(exp_fetch);
                    due_q.push_back(due);
                    last_due  = due;
                    exp_fetch = exp_fetch + 16'h0001;
                end
            end
            if (bus.instr_valid) begin
                if (first_valid < 0) first_valid = cyc;
                check_val("instr_pc", 32'(bus.instr_pc), 32'(exp_deliver));
                check_val("instruction", 32'(bus.instruction), 32'(mem_word(exp_deliver)));
                if (bus.instr_ready) begin
                    if (exp_deliver == 16'hFFFF) seen_ffff = 1'b1;
                    if (exp_deliver == 16'h0000 && seen_ffff) saw_wrap = 1'b1;
                    delivered++;
                    exp_deliver = exp_deliver + 16'h0001;
                end
            end
        end
        check_val("outstanding_bound", 32'(addr_q.size() <= MAXO), 32'd1);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            drive_inputs();
            @(negedge clk);
            observe();
        end
    endtask

    task automatic do_reset(input bit stale);
        @(negedge clk);
        reset = 1'b1;
        cyc = 0; last_due = 0;
        addr_q.delete(); due_q.delete();
        exp_fetch = 16'h0000; exp_deliver = 16'h0000;
        first_req = -1; first_valid = -1; force_redir = 1'b0;
        drive_inputs();
        bus.pcWrEn = 1'b0;
        stale_now  = stale;
        if (stale) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = 24'hBADBAD;
        end
        #1;
        observe();
        stale_now = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_req"},   32'(bus.imem_req),    32'd0);
        check_val({tag, "_addr"},  32'(bus.imem_addr),   32'h0000);
        check_val({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
        check_val({tag, "_instr"}, 32'(bus.instruction), 32'd0);
        check_val({tag, "_pc"},    32'(bus.instr_pc),    32'h0000);
    endtask

    initial begin
        int d0;
        bus.pcWrEn = 1'b0; bus.newPc = 16'h0000; bus.imem_gnt = 1'b0;
        bus.imem_rvalid = 1'b0; bus.imem_rdata = 24'h000000; bus.instr_ready = 1'b0;
        lat_min = 1; lat_max = 1; gnt_pct = 100; rdy_pct = 100; redir_pct = 0;
        delivered = 0; seen_ffff = 1'b0; saw_wrap = 1'b0; stale_now = 1'b0; cyc = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");

        // Streaming from reset with single-cycle memory
        do_reset(1'b0);
        d0 = delivered;
        step(12);
        check_val("first_req_cycle", 32'(first_req), 32'd1);
        check_val("first_valid_cycle", 32'(first_valid), 32'd3);
        check_val("stream_count", 32'(delivered - d0 >= 8), 32'd1);

        // Decode stall: FIFO fills, issue stops
        rdy_pct = 0;
        step(10);
        check_val("stall_no_req", 32'(bus.imem_req), 32'd0);
        check_val("stall_none_outstanding", 32'(addr_q.size()), 32'd0);
        check_val("stall_head_valid", 32'(bus.instr_valid), 32'd1);
        rdy_pct = 100; gnt_pct = 0;
        d0 = delivered;
        step(4);
        check_val("drain_four", 32'(delivered - d0), 32'd4);
        step(1);
        check_val("drain_empty", 32'(bus.instr_valid), 32'd0);

        // Redirect during active response/pop
        gnt_pct = 100;
        step(6);
        force_redir = 1'b1; force_pc = 16'h1234;
        step(1);
        step(1);
        check_val("redir_deliver_pc", 32'(bus.instr_pc), 32'h1234);
        step(6);

        // Redirect with several requests in flight at latency 3
        lat_min = 3; lat_max = 3;
        step(8);
        force_redir = 1'b1; force_pc = 16'h0040;
        step(1);
        d0 = delivered;
        step(14);
        check_val("redir40_delivered", 32'(delivered - d0 > 0), 32'd1);

        // PC wrap
        lat_min = 1; lat_max = 1;
        force_redir = 1'b1; force_pc = 16'hFFFE;
        step(12);
        check_val("wrap_seen", 32'(saw_wrap), 32'd1);

        // Random traffic
        lat_min = 1; lat_max = 4; gnt_pct = 70; rdy_pct = 70; redir_pct = 3;
        d0 = delivered;
        step(1500);
        check_val("random_progress", 32'(delivered - d0 > 100), 32'd1);

        // Reset mid-flight
        redir_pct = 0; rdy_pct = 0; gnt_pct = 100; lat_min = 2; lat_max = 2;
        step(4);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        bus.imem_rvalid = 1'b1;
        repeat (2) @(posedge clk);
        lat_min = 1; lat_max = 1; rdy_pct = 100;
        do_reset(1'b1);
        d0 = delivered;
        step(10);
        check_val("rst2_first_req", 32'(first_req), 32'd1);
        check_val("rst2_first_valid", 32'(first_valid), 32'd3);
        check_val("rst2_stream", 32'(delivered - d0 >= 6), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
